// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit: op encodings and the
// width-agnostic bitwise operation used by the datapath.
package logic_pkg;

  localparam int MAX_W = 64;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NOT   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  // Operates at the maximum width; callers keep only their low WIDTH bits,
  // which is exact because every operation is purely bitwise.
  function automatic logic [MAX_W-1:0] logic_op(input logic [2:0]       op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NOT:   r = ~a;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      default:  r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Pure combinational WIDTH-bit operation mux built on the shared logic_op
// function.
module logic_op_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [MAX_W-1:0] full_res;
  logic             unused_hi;

  assign full_res  = logic_op(op, MAX_W'(a), MAX_W'(b));
  assign y         = full_res[WIDTH-1:0];
  // The bits above WIDTH come from zero-extended operands and are discarded.
  assign unused_hi = ^full_res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a one-stage valid/ready output register,
// zero/parity flags, result chaining and a consumed-result counter.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] last_res;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             consume;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign a_eff    = chain ? last_res : a;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op (op),
    .a  (a_eff),
    .b  (b),
    .y  (res)
  );

  // Operands only reach the registers through accept, so stalled or
  // undriven inputs never disturb the held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      last_res  <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        y         <= res;
        zero      <= ~|res;
        parity    <= ^res;
        last_res  <= res;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed tables, corner sequences
// and randomized traffic against a truth-table based reference model.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       chain;
  logic [2:0] op;
  logic [4:0] a;
  logic [4:0] b;

  logic        in_ready, out_valid, zero, parity;
  logic [4:0]  y;
  logic [15:0] op_count;

  logic       w_in_ready, w_out_valid, w_zero, w_parity;
  logic [4:0] w_y;
  logic [2:0] w_op_count;

  int assertions = 0;
  int failures   = 0;

  logic [3:0] truth [8];

  logic        m_valid;
  logic [4:0]  m_y;
  logic [4:0]  m_last;
  int unsigned m_cnt;
  int unsigned m_cnt_w;

  typedef struct {
    logic [2:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] exp_y;
  } vec_t;

  vec_t vecs [8];
  int   wrap_seq [9];

  logic_unit_pipe #(.WIDTH(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .chain(chain), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .parity(parity),
    .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(5), .CNT_W(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .chain(chain), .a(a), .b(b), .out_valid(w_out_valid),
    .out_ready(out_ready), .y(w_y), .zero(w_zero), .parity(w_parity),
    .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each bit of the result is looked up in the operation's 2-input truth
  // table, indexed by {a_bit, b_bit}.
  function automatic logic [4:0] refOp(input logic [2:0] o, input logic [4:0] x,
                                       input logic [4:0] bb);
    logic [4:0] r;
    logic [3:0] t;
    t = truth[o];
    for (int i = 0; i < 5; i++) r[i] = t[{x[i], bb[i]}];
    return r;
  endfunction

  function automatic logic oddOnes(input logic [4:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) if (v[i]) n++;
    return (n % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic c,
                               input logic [4:0] aa, input logic [4:0] bb, input logic r);
    in_valid  = v;
    op        = o;
    chain     = c;
    a         = aa;
    b         = bb;
    out_ready = r;
  endtask

  // Advances the model by the handshake rules for the values on the inputs
  // right now, then lets the clock edge happen and settles 1 time unit.
  task automatic clockEdge();
    logic rdy, acc, cons;
    if (!rst_n) begin
      m_valid = 1'b0; m_y = '0; m_last = '0; m_cnt = 0; m_cnt_w = 0;
    end else begin
      rdy  = !m_valid || out_ready;
      acc  = in_valid && rdy;
      cons = m_valid && out_ready;
      if (acc) begin
        m_y     = refOp(op, chain ? m_last : a, b);
        m_last  = m_y;
        m_valid = 1'b1;
      end else if (cons) begin
        m_valid = 1'b0;
      end
      if (cons) begin
        m_cnt   = (m_cnt + 1) % 65536;
        m_cnt_w = (m_cnt_w + 1) % 8;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".y"},         64'(y),         64'(m_y));
    chk({tag, ".zero"},      64'(zero),      64'(m_y == 5'd0));
    chk({tag, ".parity"},    64'(parity),    64'(oddOnes(m_y)));
    chk({tag, ".op_count"},  64'(op_count),  64'(m_cnt));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(!m_valid || out_ready));
    chk({tag, ".wrap_cnt"},  64'(w_op_count), 64'(m_cnt_w));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned saved;
    truth = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1010};
    vecs[0] = '{3'd0, 5'b10110, 5'b01100, 5'b00100};
    vecs[1] = '{3'd1, 5'b10110, 5'b01100, 5'b11110};
    vecs[2] = '{3'd2, 5'b10110, 5'b01100, 5'b01001};
    vecs[3] = '{3'd3, 5'b10110, 5'b01100, 5'b11011};
    vecs[4] = '{3'd4, 5'b10110, 5'b01100, 5'b00001};
    vecs[5] = '{3'd5, 5'b10110, 5'b01100, 5'b11010};
    vecs[6] = '{3'd6, 5'b10110, 5'b01100, 5'b00101};
    vecs[7] = '{3'd7, 5'b10110, 5'b01100, 5'b01100};
    wrap_seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    m_valid = 1'b0; m_y = '0; m_last = '0; m_cnt = 0; m_cnt_w = 0;

    // Reset state
    doReset();
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.y",         64'(y),         64'd0);
    chk("reset.zero",      64'(zero),      64'd1);
    chk("reset.parity",    64'(parity),    64'd0);
    chk("reset.op_count",  64'(op_count),  64'd0);
    chk("reset.in_ready",  64'(in_ready),  64'd1);

    // Directed op sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op, 1'b0, vecs[i].a, vecs[i].b, 1'b1);
      clockEdge();
      chk($sformatf("sweep%0d.y", i), 64'(y), 64'(vecs[i].exp_y));
      chk($sformatf("sweep%0d.out_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("sweep%0d", i));
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();
    chk("sweep.op_count", 64'(op_count), 64'd8);
    chk("sweep.drained", 64'(out_valid), 64'd0);

    // Flags
    applyStimulus(1'b1, 3'd0, 1'b0, 5'b10101, 5'b01010, 1'b1);
    clockEdge();
    chk("flag_and.y", 64'(y), 64'd0);
    chk("flag_and.zero", 64'(zero), 64'd1);
    chk("flag_and.parity", 64'(parity), 64'd0);
    applyStimulus(1'b1, 3'd1, 1'b0, 5'b10101, 5'b01010, 1'b1);
    clockEdge();
    chk("flag_or.y", 64'(y), 64'h1f);
    chk("flag_or.zero", 64'(zero), 64'd0);
    chk("flag_or.parity", 64'(parity), 64'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();

    // Chain from reset, back-to-back
    doReset();
    applyStimulus(1'b1, 3'd1, 1'b1, 5'b11100, 5'b00011, 1'b1);
    clockEdge();
    chk("chain1.y", 64'(y), 64'b00011);
    applyStimulus(1'b1, 3'd5, 1'b1, 5'b11111, 5'b00001, 1'b1);
    clockEdge();
    chk("chain2.y", 64'(y), 64'b00010);
    chk("chain2.out_valid", 64'(out_valid), 64'd1);
    checkOutput("chain2");
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();

    // Backpressure: stall holds everything, then consume+accept together
    applyStimulus(1'b1, 3'd7, 1'b0, 5'd0, 5'b10101, 1'b0);
    clockEdge();
    saved = 32'(op_count);
    applyStimulus(1'b1, 3'd7, 1'b0, 5'd3, 5'b01010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      clockEdge();
      chk($sformatf("stall%0d.in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d.y", i), 64'(y), 64'b10101);
      chk($sformatf("stall%0d.op_count", i), 64'(op_count), 64'(saved));
      checkOutput($sformatf("stall%0d", i));
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    clockEdge();
    chk("release.out_valid", 64'(out_valid), 64'd1);
    chk("release.y", 64'(y), 64'b01010);
    chk("release.op_count", 64'(op_count), 64'(saved + 1));
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();

    // Reset during a stall
    applyStimulus(1'b1, 3'd7, 1'b0, 5'd0, 5'b11111, 1'b0);
    clockEdge();
    rst_n = 1'b0;
    applyStimulus(1'b1, 3'd7, 1'b0, 5'd0, 5'b01110, 1'b0);
    clockEdge();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rststall.out_valid", 64'(out_valid), 64'd0);
    chk("rststall.y", 64'(y), 64'd0);
    chk("rststall.zero", 64'(zero), 64'd1);
    chk("rststall.op_count", 64'(op_count), 64'd0);
    chk("rststall.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 3'd1, 1'b1, 5'b11111, 5'b00100, 1'b1);
    clockEdge();
    chk("rststall.chain_y", 64'(y), 64'b00100);
    applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    clockEdge();

    // Counter wrap on the 3-bit instance
    doReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 5'($urandom), 5'($urandom), 1'b1);
      clockEdge();
      if (k >= 2) chk($sformatf("wrap%0d", k - 2), 64'(w_op_count), 64'(wrap_seq[k - 2]));
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                    1'($urandom_range(0, 3) != 0));
      clockEdge();
      checkOutput($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
